// File: rtl/lif_accumulate_fire.sv
// lif_accumulate_fire: integrate-and-fire stage for one neuron group.
// Loads decayed potentials, accumulates N beats of signed synaptic currents
// with saturation, compares against a latched threshold, and presents the
// spike vector plus updated potentials for the save path.
// Build option: define SUBTRACT_RESET_EN for soft reset (fired neurons keep
// sat(acc - thr)); leave it undefined for hard reset (fired neurons go to 0).
`timescale 1ns/1ps
module lif_accumulate_fire #(
  parameter int NEURONS = 16,
  parameter int POT_W   = 8,
  parameter int BEAT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BEAT_W-1:0]          beats,
  input  logic [POT_W-1:0]           threshold,
  input  logic [NEURONS*POT_W-1:0]   decay_16n_potential_in,
  input  logic                       cur_valid,
  input  logic [NEURONS*POT_W-1:0]   cur_16n_in,
  output logic                       cur_ready,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEURONS*POT_W-1:0]   spk_16n_potential_out,
  output logic [NEURONS-1:0]         spk_16n_spk_out
);

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE, HOLD} state_t;

  state_t                     state_q, state_d;
  logic [NEURONS*POT_W-1:0]   acc_q, acc_d;
  logic [NEURONS*POT_W-1:0]   pot_q, pot_d;
  logic [NEURONS-1:0]         spk_q, spk_d;
  logic [POT_W-1:0]           thr_q, thr_d;
  logic [BEAT_W-1:0]          cnt_q, cnt_d;
  logic                       cur_ready_q, cur_ready_d;
  logic                       busy_q, busy_d;
  logic                       out_valid_q, out_valid_d;

  // Per-neuron datapath results, consumed by the state machine.
  logic [NEURONS*POT_W-1:0]   acc_sum;
  logic [NEURONS*POT_W-1:0]   fire_pot;
  logic [NEURONS-1:0]         fire_spk;

  // Clamp a one-bit-wider signed sum back into POT_W bits.
  function automatic logic [POT_W-1:0] sat(input logic [POT_W:0] s);
    if (s[POT_W] != s[POT_W-1])
      return s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
    return s[POT_W-1:0];
  endfunction

  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
    logic [POT_W-1:0] acc_i;
    logic [POT_W-1:0] cur_i;
    logic [POT_W:0]   sum_i;
    logic [POT_W-1:0] reset_val_i;

    assign acc_i = acc_q[gi*POT_W +: POT_W];
    assign cur_i = cur_16n_in[gi*POT_W +: POT_W];
    // Sign-extend both operands by one bit so the sum never wraps before clamping.
    assign sum_i = {acc_i[POT_W-1], acc_i} + {cur_i[POT_W-1], cur_i};
    assign acc_sum[gi*POT_W +: POT_W] = sat(sum_i);

    assign fire_spk[gi] = ($signed(acc_i) >= $signed(thr_q));

`ifdef SUBTRACT_RESET_EN
    logic [POT_W:0] diff_i;
    // Soft reset keeps the residual above threshold.
    assign diff_i      = {acc_i[POT_W-1], acc_i} - {thr_q[POT_W-1], thr_q};
    assign reset_val_i = sat(diff_i);
`else
    assign reset_val_i = '0;
`endif

    assign fire_pot[gi*POT_W +: POT_W] = fire_spk[gi] ? reset_val_i : acc_i;
  end

  // Next-state and next-output computation for the group sequencer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pot_d       = pot_q;
    spk_d       = spk_q;
    thr_d       = thr_q;
    cnt_d       = cnt_q;
    cur_ready_d = cur_ready_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d  = decay_16n_potential_in;
          thr_d  = threshold;
          cnt_d  = beats;
          busy_d = 1'b1;
          if (beats != '0) begin
            state_d     = ACCUM;
            cur_ready_d = 1'b1;
          end else begin
            state_d = FIRE;
          end
        end
      end
      ACCUM: begin
        if (cur_valid && cur_ready_q) begin
          acc_d = acc_sum;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BEAT_W'(1)) begin
            state_d     = FIRE;
            cur_ready_d = 1'b0;
          end
        end
      end
      FIRE: begin
        pot_d       = fire_pot;
        spk_d       = fire_spk;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        // Data outputs are left untouched so they keep their last value.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight group and clears every output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      pot_q       <= '0;
      spk_q       <= '0;
      thr_q       <= '0;
      cnt_q       <= '0;
      cur_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pot_q       <= pot_d;
      spk_q       <= spk_d;
      thr_q       <= thr_d;
      cnt_q       <= cnt_d;
      cur_ready_q <= cur_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign cur_ready             = cur_ready_q;
  assign busy                  = busy_q;
  assign out_valid             = out_valid_q;
  assign spk_16n_potential_out = pot_q;
  assign spk_16n_spk_out       = spk_q;

endmodule

// File: tb/tb_lif_accumulate_fire.sv
// Testbench for lif_accumulate_fire: directed cases plus randomized groups,
// checked through a result scoreboard fed by an arithmetic reference model.
`timescale 1ns/1ps
module tb_lif_accumulate_fire;
  localparam int N  = 16;
  localparam int W  = 8;
  localparam int BW = 8;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [BW-1:0] beats;
  logic [W-1:0]  threshold;
  logic [DW-1:0] decay_in;
  logic          cur_valid;
  logic [DW-1:0] cur_in;
  logic          cur_ready;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] pot_out;
  logic [N-1:0]  spk_out;

  lif_accumulate_fire #(.NEURONS(N), .POT_W(W), .BEAT_W(BW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .beats                  (beats),
    .threshold              (threshold),
    .decay_16n_potential_in (decay_in),
    .cur_valid              (cur_valid),
    .cur_16n_in             (cur_in),
    .cur_ready              (cur_ready),
    .busy                   (busy),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .spk_16n_potential_out  (pot_out),
    .spk_16n_spk_out        (spk_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] pot;
    logic [N-1:0]  spk;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] cur_mem [0:7];
  int            checks = 0;
  int            errors = 0;
  logic          hold_low = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference: integer accumulation with clamping, then threshold compare.
  function automatic exp_t model(input int nb, input logic [W-1:0] thr, input logic [DW-1:0] pot);
    exp_t e;
    int a, t, p;
    t = int'($signed(thr));
    for (int i = 0; i < N; i++) begin
      a = int'($signed(pot[W*i +: W]));
      for (int b = 0; b < nb; b++) a = clamp(a + int'($signed(cur_mem[b][W*i +: W])));
      e.spk[i] = (a >= t);
      if (a >= t) begin
`ifdef SUBTRACT_RESET_EN
        p = clamp(a - t);
`else
        p = 0;
`endif
      end else begin
        p = a;
      end
      e.pot[W*i +: W] = p[W-1:0];
    end
    return e;
  endfunction

  // Downstream backpressure: random ready unless a test forces it low.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare each accepted result with the scoreboard and check stalls.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_pot;
  logic [N-1:0]  prev_spk;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (stall_prev) begin
        chk("hold_valid", DW'(out_valid), DW'(1));
        chk("hold_pot", pot_out, prev_pot);
        chk("hold_spk", DW'(spk_out), DW'(prev_spk));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got spk %0h expected no result", spk_out);
        end else begin
          e = sb.pop_front();
          chk("result_pot", pot_out, e.pot);
          chk("result_spk", DW'(spk_out), DW'(e.spk));
        end
      end
      stall_prev <= out_valid && !out_ready;
      prev_pot   <= pot_out;
      prev_spk   <= spk_out;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    if (busy) chk("idle_timeout", DW'(busy), DW'(0));
  endtask

  task automatic issue_start(input int nb, input logic [W-1:0] thr, input logic [DW-1:0] pot, output int t0);
    start     = 1'b1;
    beats     = BW'(nb);
    threshold = thr;
    decay_in  = pot;
    t0        = cyc;
    step();
    start     = 1'b0;
    threshold = W'($urandom);
    decay_in  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out_valid(input int t0, input int nb, input bit lat_check);
    int n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk("out_valid_seen", DW'(out_valid), DW'(1));
    if (lat_check) chk("latency", DW'(cyc - t0), DW'(nb + 2));
  endtask

  // One full group: model + push, start, feed currents with optional gaps.
  task automatic run_group(input int nb, input logic [W-1:0] thr, input logic [DW-1:0] pot,
                           input int gap_pct, input bit lat_check);
    int t0, k, n;
    wait_idle();
    sb.push_back(model(nb, thr, pot));
    issue_start(nb, thr, pot, t0);
    k = 0;
    n = 0;
    while (k < nb && n < 500) begin
      cur_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
      cur_in    = cur_valid ? cur_mem[k] : {$urandom, $urandom, $urandom, $urandom};
      if (cur_valid && cur_ready) k++;
      step();
      n++;
    end
    cur_valid = 1'b0;
    chk("beats_taken", DW'(k), DW'(nb));
    chk("cur_ready_after_last", DW'(cur_ready), DW'(0));
    wait_out_valid(t0, nb, lat_check);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] pv;
    logic [DW-1:0] snap_pot;
    int            t0, k, n;
    bit            pat [0:4];

    reset = 1'b1; start = 1'b0; beats = '0; threshold = '0;
    decay_in = '0; cur_valid = 1'b0; cur_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_cur_ready", DW'(cur_ready), DW'(0));
    chk("reset_busy", DW'(busy), DW'(0));
    chk("reset_out_valid", DW'(out_valid), DW'(0));
    chk("reset_pot", pot_out, DW'(0));
    chk("reset_spk", DW'(spk_out), DW'(0));

    // Directed 1: threshold reached exactly by every neuron.
    cur_mem[0] = {N{8'd20}};
    cur_mem[1] = {N{8'd20}};
    run_group(2, 8'd50, {N{8'd10}}, 0, 1'b1);
    chk("t1_spk", DW'(spk_out), DW'(16'hFFFF));
    chk("t1_pot", pot_out, DW'(0));

    // Directed 2: positive saturation fires, negative saturation does not.
    pv = '0; pv[7:0] = 8'd120; pv[15:8] = 8'h9C;
    cur_mem[0] = '0; cur_mem[0][7:0] = 8'd100; cur_mem[0][15:8] = 8'h9C;
    run_group(1, 8'd127, pv, 0, 1'b1);
    chk("t2_spk", DW'(spk_out), DW'(16'h0001));
    chk("t2_pot_n0", DW'(pot_out[7:0]), DW'(0));
    chk("t2_pot_n1", DW'(pot_out[15:8]), DW'(8'h80));

    // Directed 3: zero beats goes straight to the compare.
    pv = '0; pv[31:24] = 8'd60;
    run_group(0, 8'd40, pv, 0, 1'b1);
    chk("t3_spk", DW'(spk_out), DW'(16'h0008));
`ifdef SUBTRACT_RESET_EN
    chk("t3_pot_n3", DW'(pot_out[31:24]), DW'(20));
`else
    chk("t3_pot_n3", DW'(pot_out[31:24]), DW'(0));
`endif

    // Directed 4: gapped currents, held backpressure, start ignored in HOLD.
    wait_idle();
    hold_low = 1'b1;
    for (int b = 0; b < 3; b++) cur_mem[b] = {$urandom, $urandom, $urandom, $urandom};
    pv = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back(model(3, 8'd5, pv));
    issue_start(3, 8'd5, pv, t0);
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
    k = 0;
    for (int p = 0; p < 5; p++) begin
      cur_valid = pat[p];
      cur_in    = pat[p] ? cur_mem[k] : {$urandom, $urandom, $urandom, $urandom};
      if (cur_valid && cur_ready) k++;
      step();
    end
    cur_valid = 1'b1;
    cur_in    = {$urandom, $urandom, $urandom, $urandom};
    chk("t4_transfers", DW'(k), DW'(3));
    chk("t4_cur_ready_low", DW'(cur_ready), DW'(0));
    step();
    cur_valid = 1'b0;
    wait_out_valid(t0, 3, 1'b0);
    snap_pot = pot_out;
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; beats = '0; threshold = 8'h80;
      step();
    end
    start = 1'b0;
    chk("t4_still_valid", DW'(out_valid), DW'(1));
    chk("t4_pot_stable", pot_out, snap_pot);
    hold_low = 1'b0;
    n = 0;
    while (out_valid && n < 50) begin step(); n++; end
    step();
    chk("t4_no_restart", DW'(busy), DW'(0));

    // Directed 5: reset mid-accumulation drops the group entirely.
    wait_idle();
    cur_mem[0] = {N{8'd7}};
    issue_start(4, 8'd0, {N{8'd3}}, t0);
    cur_valid = 1'b1;
    cur_in    = cur_mem[0];
    step();
    cur_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_out_valid", DW'(out_valid), DW'(0));
    chk("t5_busy", DW'(busy), DW'(0));
    chk("t5_cur_ready", DW'(cur_ready), DW'(0));
    chk("t5_pot", pot_out, DW'(0));
    chk("t5_spk", DW'(spk_out), DW'(0));
    cur_mem[0] = {N{8'd1}};
    cur_mem[1] = {N{8'd1}};
    run_group(2, 8'd10, {N{8'd4}}, 0, 1'b1);
    chk("t5_fresh_spk", DW'(spk_out), DW'(0));
    chk("t5_fresh_pot", pot_out, {N{8'd6}});

    // Randomized groups with gaps and backpressure.
    for (int g = 0; g < 40; g++) begin
      int nb;
      nb = $urandom_range(0, 6);
      for (int b = 0; b < nb; b++) cur_mem[b] = {$urandom, $urandom, $urandom, $urandom};
      run_group(nb, W'($urandom), {$urandom, $urandom, $urandom, $urandom}, 30, 1'b0);
    end

    n = 0;
    while (sb.size() != 0 && n < 300) begin step(); n++; end
    chk("scoreboard_drained", DW'(sb.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
